// File: rtl/even_parity_pkg.sv
// Shared types and default constants for the even-parity serial receiver.
// Contents: frame state enum, data width, inter-bit timeout, error counter width.
// Imported by even_parity_serial_rx and evenpar_shift_reg.
package even_parity_pkg;

  localparam int DATA_W_DEF  = 4;
  localparam int TIMEOUT_DEF = 15;
  localparam int ERR_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

endpackage

// File: rtl/evenpar_shift_reg.sv
// Serial-in/parallel-out shift register, MSB first (left shift, new bit enters at LSB).
// Ports: clk, rst_n (sync, active-low), load_first (start a new word with bit_in),
//        shift_en (append bit_in), clr (discard), bit_in, data (word), cnt (bits held).
module evenpar_shift_reg
  import even_parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_first,
  input  logic              shift_en,
  input  logic              clr,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (load_first) begin
      // A frame-start bit always restarts the word, whatever was collected.
      data <= {{(DATA_W-1){1'b0}}, bit_in};
      cnt  <= CNT_W'(1);
    end else if (clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      data <= {data[DATA_W-2:0], bit_in};
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/even_parity_serial_rx.sv
// Serial frame receiver: DATA_W data bits (MSB first) + even-parity bit, with a
// one-entry valid/ready output buffer, resync, inter-bit timeout and overrun pulses.
// Ports: clk, rst_n, bit_in/bit_valid/frame_sync in; data_out/parity_ok/out_valid/out_ready
//        handshake; overrun and frame_abort one-cycle pulses. Macro EVEN_PARITY_ERR_CNT_EN adds err_cnt.
module even_parity_serial_rx
  import even_parity_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
`ifdef EVEN_PARITY_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic              frame_abort
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t state, state_nxt;

  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] sr_data;
  logic [CNT_W-1:0]  sr_cnt;

  logic start;     // strobed frame-start bit, accepted in any state
  logic resync;    // frame-start bit arriving mid-frame
  logic data_bit;  // ordinary data bit while collecting
  logic complete;  // parity bit received
  logic to_hit;    // idle cycle that brings the timeout count to TIMEOUT
  logic can_load;  // buffer empty or being drained this cycle

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = DATA;
      DATA: begin
        if (start)                                     state_nxt = DATA;
        else if (data_bit && sr_cnt == CNT_W'(DATA_W-1)) state_nxt = PAR;
        else if (to_hit)                               state_nxt = IDLE;
      end
      PAR: begin
        if (start)                 state_nxt = DATA;
        else if (complete || to_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- output / control decode ----------------
  always_comb begin
    start    = bit_valid && frame_sync;
    resync   = start && (state != IDLE);
    data_bit = bit_valid && !frame_sync && (state == DATA);
    complete = bit_valid && !frame_sync && (state == PAR);
    // bit_valid wins over a timeout on the same cycle, so only idle cycles can expire.
    to_hit   = (state != IDLE) && !bit_valid && (to_cnt == TO_W'(TIMEOUT-1));
    can_load = !out_valid || out_ready;
  end

  evenpar_shift_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_sr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_first (start),
    .shift_en   (data_bit),
    .clr        (to_hit),
    .bit_in     (bit_in),
    .data       (sr_data),
    .cnt        (sr_cnt)
  );

  // Inter-bit idle counter; only runs while a frame is open.
  always_ff @(posedge clk) begin
    if (!rst_n)                                      to_cnt <= '0;
    else if (state == IDLE || bit_valid || to_hit)   to_cnt <= '0;
    else                                             to_cnt <= to_cnt + TO_W'(1);
  end

  // Output buffer and event pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out    <= '0;
      parity_ok   <= 1'b0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      overrun     <= complete && !can_load;
      frame_abort <= resync || to_hit;
      if (complete && can_load) begin
        data_out  <= sr_data;
        parity_ok <= ~(^{sr_data, bit_in});
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef EVEN_PARITY_ERR_CNT_EN
  logic err_evt;
  assign err_evt = complete && (!can_load || (^{sr_data, bit_in}));

  always_ff @(posedge clk) begin
    if (!rst_n)                                    err_cnt <= '0;
    else if (err_evt && err_cnt != {ERR_CNT_W{1'b1}}) err_cnt <= err_cnt + ERR_CNT_W'(1);
  end
`endif

endmodule

// File: doc/even_parity_serial_rx.md
Name: even_parity_serial_rx

Overview:
- Upstream stage of the 4-bit even-parity checker.
- Collects a serial frame: 4 data bits, MSB first, followed by 1 parity bit.
- Presents the assembled nibble with an even-parity verdict through a one-entry valid/ready output buffer.
- Handles frame resync, inter-bit timeout and output overrun.

Parameters:
- DATA_W, 4, data bits per frame. Output nibble bit order is a,b,c,d, with a as the MSB.
- TIMEOUT, 15, maximum idle clock cycles allowed between bits inside a frame.
- TO_W, $clog2(TIMEOUT+1), width of the timeout counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- bit_in  in  1  serial data bit, sampled when bit_valid=1.
- bit_valid  in  1  strobe qualifying bit_in, one bit per asserted cycle.
- frame_sync  in  1  marks the current bit_valid bit as the first bit of a frame. Ignored when bit_valid=0.
- data_out  out  DATA_W  assembled data. Bit order a,b,c,d maps to [3:0].
- parity_ok  out  1  1 when XOR of data_out and the received parity bit is 0.
- out_valid  out  1  buffer holds an unconsumed frame.
- out_ready  in  1  consumer accepts the frame when out_valid && out_ready.
- overrun  out  1  one-cycle pulse: a completed frame was dropped because the buffer was full.
- frame_abort  out  1  one-cycle pulse: a partial frame was discarded.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, bit counter 0, timeout counter 0, shift register 0; data_out=0, parity_ok=0, out_valid=0, overrun=0, frame_abort=0.
- Reset takes priority over every other event, including mid-frame. No pulses are emitted by reset.
- States: IDLE, DATA, PAR.
- IDLE:
  - bit_valid && frame_sync: shift bit_in in, bit counter=1, go to DATA.
  - bit_valid without frame_sync: ignored.
- DATA:
  - Each bit_valid shifts bit_in in at the LSB with a left shift.
  - After DATA_W bits have been received, go to PAR.
- PAR:
  - The next bit_valid bit is the parity bit.
  - Frame completes and the state returns to IDLE.
- Resync: frame_sync && bit_valid while in DATA or PAR:
  - frame_abort pulses on the next cycle.
  - The partial frame is discarded.
  - The strobed bit starts a new frame (counter=1, state DATA).
- Timeout:
  - In DATA or PAR, the timeout counter increments on each cycle without bit_valid and clears to 0 on every bit_valid.
  - When the count reaches TIMEOUT: frame_abort pulses, state goes to IDLE, and no output is produced.
- Completion:
  - If the buffer is empty, or is being drained in the same cycle (out_valid && out_ready), the frame loads.
  - Load means: data_out gets the nibble, parity_ok gets ~(^{nibble,parity}), and out_valid=1 starting the next cycle. Latency is 1 cycle from parity-bit sample to out_valid.
  - Otherwise overrun pulses the next cycle, the frame is dropped, and the buffer is unchanged.
- Output hold: while out_valid=1 && out_ready=0, data_out and parity_ok are held stable.
  - out_valid clears the cycle after a handshake, unless a new frame loads in that same cycle.
- Simultaneous events: a timeout match and bit_valid in the same cycle resolve as bit_valid (the bit is taken and the counter clears).

Optional Feature:
- Macro: EVEN_PARITY_ERR_CNT_EN.
- When defined:
  - Adds output port err_cnt (8-bit), reset to 0.
  - err_cnt increments by 1 each time a frame loads with parity_ok=0, and also on each overrun pulse.
  - Saturates at 255.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package even_parity_pkg:
  - state enum (IDLE, DATA, PAR).
  - DATA_W default constant.
  - TIMEOUT default constant.
  - ERR_CNT_W=8.
- Sub-module evenpar_shift_reg:
  - Serial-in/parallel-out DATA_W shift register with a load-first-bit (sync) input and a bit count output.
  - The top level holds the FSM, timeout counter, output buffer and pulses.

Test Plan:
1. Sync frame 1,0,1,1 followed by parity 1, with out_ready=1 → 1 cycle after the parity bit: out_valid=1, data_out=4'b1011, parity_ok=1.
2. Same data with parity 0 → data_out=4'b1011, parity_ok=0. With EVEN_PARITY_ERR_CNT_EN defined, err_cnt goes 0→1.
3. out_ready=0; send frame 4'b0011 with parity 0, then frame 4'b0101 with parity 0 → second completion gives an overrun pulse of 1 cycle; data_out stays 4'b0011 and parity_ok stays 1.
4. Send 2 bits, then hold bit_valid=0 → frame_abort pulses after 15 idle cycles, state is IDLE, out_valid stays 0. A following bit without frame_sync is ignored.
5. Send 3 bits, then a frame_sync bit, then bits 1,1,0 and parity 1 → frame_abort pulses once; the resulting output is data_out equal to the sync bit followed by 1,1,0.
6. Drive rst_n=0 for one cycle after 3 bits, then send a full frame 4'b1111 with parity 0 → no pulses from the reset; data_out=4'b1111, parity_ok=1.
